// File: rtl/pipe_id_stage.sv
// Decode stage: IF/ID register, register file with WB write-through,
// EX/MEM/WB operand forwarding, load-use stall and immediate/shift-amount select.
module pipe_id_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int FWD_EN = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [31:0]     if_inst,
  input  logic            if_valid,
  input  logic            flush,
  output logic            id_stall,
  output logic [11:0]     id_op,
  input  logic            cu_wreg,
  input  logic            cu_m2reg,
  input  logic            cu_wmem,
  input  logic            cu_sst,
  input  logic            cu_sext,
  input  logic            cu_shift,
  input  logic            cu_aluimm,
  input  logic            cu_rs_used,
  input  logic            cu_rt_used,
  input  logic [3:0]      cu_aluc,
  input  logic            ex_wreg,
  input  logic            ex_m2reg,
  input  logic [AW-1:0]   ex_wn,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_wreg,
  input  logic [AW-1:0]   mem_wn,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_wreg,
  input  logic [AW-1:0]   wb_wn,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic            id_wreg,
  output logic            id_m2reg,
  output logic            id_wmem,
  output logic            id_shift,
  output logic            id_aluimm,
  output logic [3:0]      id_aluc,
  output logic [AW-1:0]   id_wn,
  output logic [XLEN-1:0] id_qa,
  output logic [XLEN-1:0] id_qb,
  output logic [XLEN-1:0] id_imm_or_sa
);

  localparam bit FWD = (FWD_EN != 0);

  logic [31:0]     inst_r;
  logic            valid_r;
  logic [XLEN-1:0] regs_r [NREG];

  logic [AW-1:0]   src_s [2];
  logic            used_s [2];
  logic [XLEN-1:0] rfq_s [2];
  logic [XLEN-1:0] opnd_s [2];
  logic            hz_s [2];
  logic            ex_hit_s [2];
  logic            mem_hit_s [2];
  logic [AW-1:0]   rd_s;
  logic            stall_s;
  logic            live_s;
  logic [15:0]     imm_s;
  logic            unused_fields;

  assign src_s[0]  = inst_r[5 +: AW];
  assign src_s[1]  = inst_r[0 +: AW];
  assign rd_s      = inst_r[10 +: AW];
  assign used_s[0] = cu_rs_used;
  assign used_s[1] = cu_rt_used;
  assign imm_s     = inst_r[25:10];
  assign unused_fields = ^inst_r[14:0];

  // IF/ID register: flush beats stall, stall holds, otherwise load
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (!stall_s) begin
      inst_r  <= if_inst;
      valid_r <= if_valid;
    end
  end

  // Register file; entry 0 is never written
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else if (wb_wreg && (wb_wn != '0)) begin
      regs_r[wb_wn] <= wb_data;
    end
  end

  // Operand read with WB write-through, forwarding mux and hazard detection
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ex_hit_s[i]  = ex_wreg && (ex_wn == src_s[i]) && (src_s[i] != '0);
      mem_hit_s[i] = mem_wreg && (mem_wn == src_s[i]) && (src_s[i] != '0);
      if (src_s[i] == '0) begin
        rfq_s[i] = '0;
      end else if (wb_wreg && (wb_wn == src_s[i])) begin
        rfq_s[i] = wb_data;
      end else begin
        rfq_s[i] = regs_r[src_s[i]];
      end
      if (FWD && ex_hit_s[i] && !ex_m2reg) begin
        opnd_s[i] = ex_result;
      end else if (FWD && mem_hit_s[i]) begin
        opnd_s[i] = mem_result;
      end else begin
        opnd_s[i] = rfq_s[i];
      end
      // Without forwarding any in-flight producer must drain to WB first
      hz_s[i] = valid_r && used_s[i] &&
                ((ex_hit_s[i] && (ex_m2reg || !FWD)) || (mem_hit_s[i] && !FWD));
    end
  end

  assign stall_s = hz_s[0] || hz_s[1];
  assign live_s  = valid_r && !stall_s;

  // Immediate / shift-amount select
  always_comb begin
    if (cu_shift) begin
      id_imm_or_sa = {{(XLEN-5){1'b0}}, inst_r[19:15]};
    end else if (cu_sext) begin
      id_imm_or_sa = {{(XLEN-16){imm_s[15]}}, imm_s};
    end else begin
      id_imm_or_sa = {{(XLEN-16){1'b0}}, imm_s};
    end
  end

  assign id_stall  = stall_s;
  assign id_op     = inst_r[31:20];
  assign id_valid  = live_s;
  assign id_wreg   = live_s && cu_wreg;
  assign id_m2reg  = live_s && cu_m2reg;
  assign id_wmem   = live_s && cu_wmem;
  assign id_aluc   = live_s ? cu_aluc : 4'h0;
  assign id_shift  = cu_shift;
  assign id_aluimm = cu_aluimm;
  assign id_wn     = cu_sst ? src_s[1] : rd_s;
  assign id_qa     = opnd_s[0];
  assign id_qb     = opnd_s[1];

endmodule
